// File: rtl/morse_key_sequencer.sv
// Morse key sequencer: times mark/space durations of a debounced key, collects
// up to five dot/dash elements per letter and emits symbol indices or error strobes.
module morse_key_sequencer #(
  parameter int unsigned UNIT_CYCLES = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key,
  output logic [5:0] morse,
  output logic       morseReady,
  output logic       symbolError,
  output logic       busy
);

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned PAT_W   = 5;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned SYM_W   = 6;

  localparam logic [CNT_W-1:0] MARK_SAT   = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(7 * UNIT_CYCLES);
  localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(PAT_W);
  localparam logic [SYM_W-1:0] SPACE_SYM  = SYM_W'(36);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_WORDGAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   mark_cnt_q, mark_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [SYM_W-1:0]   morse_q, morse_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [CNT_W-1:0]   gap_inc;
  logic               is_dash;
  logic [SYM_W:0]     letter;

  // Pattern is shifted in MSB-first (first element highest), dot = 0, dash = 1.
  // Returns {valid, symbol index}.
  function automatic logic [SYM_W:0] decode(input logic [LEN_W-1:0] len,
                                            input logic [PAT_W-1:0] pat);
    logic [SYM_W:0] res;
    res = '0;
    case ({len, pat})
      {3'd2, 5'b00001}: res = {1'b1, 6'd10};  // A .-
      {3'd4, 5'b01000}: res = {1'b1, 6'd11};  // B -...
      {3'd4, 5'b01010}: res = {1'b1, 6'd12};  // C -.-.
      {3'd3, 5'b00100}: res = {1'b1, 6'd13};  // D -..
      {3'd1, 5'b00000}: res = {1'b1, 6'd14};  // E .
      {3'd4, 5'b00010}: res = {1'b1, 6'd15};  // F ..-.
      {3'd3, 5'b00110}: res = {1'b1, 6'd16};  // G --.
      {3'd4, 5'b00000}: res = {1'b1, 6'd17};  // H ....
      {3'd2, 5'b00000}: res = {1'b1, 6'd18};  // I ..
      {3'd4, 5'b00111}: res = {1'b1, 6'd19};  // J .---
      {3'd3, 5'b00101}: res = {1'b1, 6'd20};  // K -.-
      {3'd4, 5'b00100}: res = {1'b1, 6'd21};  // L .-..
      {3'd2, 5'b00011}: res = {1'b1, 6'd22};  // M --
      {3'd2, 5'b00010}: res = {1'b1, 6'd23};  // N -.
      {3'd3, 5'b00111}: res = {1'b1, 6'd24};  // O ---
      {3'd4, 5'b00110}: res = {1'b1, 6'd25};  // P .--.
      {3'd4, 5'b01101}: res = {1'b1, 6'd26};  // Q --.-
      {3'd3, 5'b00010}: res = {1'b1, 6'd27};  // R .-.
      {3'd3, 5'b00000}: res = {1'b1, 6'd28};  // S ...
      {3'd1, 5'b00001}: res = {1'b1, 6'd29};  // T -
      {3'd3, 5'b00001}: res = {1'b1, 6'd30};  // U ..-
      {3'd4, 5'b00001}: res = {1'b1, 6'd31};  // V ...-
      {3'd3, 5'b00011}: res = {1'b1, 6'd32};  // W .--
      {3'd4, 5'b01001}: res = {1'b1, 6'd33};  // X -..-
      {3'd4, 5'b01011}: res = {1'b1, 6'd34};  // Y -.--
      {3'd4, 5'b01100}: res = {1'b1, 6'd35};  // Z --..
      {3'd5, 5'b11111}: res = {1'b1, 6'd0};
      {3'd5, 5'b01111}: res = {1'b1, 6'd1};
      {3'd5, 5'b00111}: res = {1'b1, 6'd2};
      {3'd5, 5'b00011}: res = {1'b1, 6'd3};
      {3'd5, 5'b00001}: res = {1'b1, 6'd4};
      {3'd5, 5'b00000}: res = {1'b1, 6'd5};
      {3'd5, 5'b10000}: res = {1'b1, 6'd6};
      {3'd5, 5'b11000}: res = {1'b1, 6'd7};
      {3'd5, 5'b11100}: res = {1'b1, 6'd8};
      {3'd5, 5'b11110}: res = {1'b1, 6'd9};
      default:          res = '0;
    endcase
    return res;
  endfunction

  assign gap_inc = gap_cnt_q + CNT_W'(1);
  assign is_dash = (mark_cnt_q >= MARK_SAT);
  assign letter  = decode(len_q, pat_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    mark_cnt_d = mark_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    morse_d    = morse_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key) begin
          state_d    = ST_MARK;
          mark_cnt_d = CNT_W'(1);
        end
      end

      ST_MARK: begin
        if (key) begin
          if (mark_cnt_q < MARK_SAT) begin
            mark_cnt_d = mark_cnt_q + CNT_W'(1);
          end
        end else begin
          if (len_q < MAX_LEN) begin
            pat_d = {pat_q[PAT_W-2:0], is_dash};
            len_d = len_q + LEN_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          gap_cnt_d = CNT_W'(1);
          state_d   = ST_SPACE;
        end
      end

      ST_SPACE: begin
        if (key) begin
          state_d    = ST_MARK;
          mark_cnt_d = CNT_W'(1);
          gap_cnt_d  = '0;
        end else begin
          gap_cnt_d = gap_inc;
          if (gap_inc == LETTER_GAP) begin
            if (!ovf_q && letter[SYM_W]) begin
              ready_d = 1'b1;
              morse_d = letter[SYM_W-1:0];
            end else begin
              err_d = 1'b1;
            end
            pat_d   = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_WORDGAP;
          end
        end
      end

      ST_WORDGAP: begin
        if (key) begin
          state_d    = ST_MARK;
          mark_cnt_d = CNT_W'(1);
          gap_cnt_d  = '0;
        end else begin
          gap_cnt_d = gap_inc;
          if (gap_inc == WORD_GAP) begin
            ready_d   = 1'b1;
            morse_d   = SPACE_SYM;
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mark_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      morse_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mark_cnt_q <= mark_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      morse_q    <= morse_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign morse       = morse_q;
  assign morseReady  = ready_q;
  assign symbolError = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Scoreboard bench for morse_key_sequencer with UNIT_CYCLES = 4.
module tb_morse_key_sequencer;

  localparam int unsigned UNIT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       key;
  logic [5:0] morse;
  logic       morseReady;
  logic       symbolError;
  logic       busy;

  morse_key_sequencer #(.UNIT_CYCLES(UNIT)) dut (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .morse       (morse),
    .morseReady  (morseReady),
    .symbolError (symbolError),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         err;
    logic [5:0] sym;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] model_morse = 6'd0;

  // n samples of key level k, each sampled at the following rising edge
  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      key = k;
    end
  endtask

  // The sample just driven is a threshold: a strobe is due one cycle after it
  task automatic expect_strobe(input bit err, input logic [5:0] sym);
    exp_t e;
    e.cyc = cyc + 1;
    e.err = err;
    e.sym = err ? model_morse : sym;
    if (!err) model_morse = sym;
    exp_q.push_back(e);
  endtask

  task automatic dot();
    hold(1'b1, UNIT);
  endtask

  task automatic dash();
    hold(1'b1, 2 * UNIT);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key   = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++;
    if (morse !== 6'd0 || morseReady !== 1'b0 || symbolError !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got morse=%0d ready=%b err=%b busy=%b, want 0/0/0/0",
               morse, morseReady, symbolError, busy);
    end
    reset = 1'b0;
    key   = 1'b0;
    model_morse = 6'd0;
    hold(1'b0, 2);
  endtask

  task automatic test_letter_e();
    hold(1'b1, UNIT);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_in_mark: got %b, want 1", busy);
    end
    hold(1'b0, 12);
    expect_strobe(1'b0, 6'd14);
    hold(1'b0, 16);
    expect_strobe(1'b0, 6'd36);
    hold(1'b0, 2);
    n_vec++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL letter_e_end: got busy=%b pending=%0d, want busy=0 pending=0",
               busy, exp_q.size());
    end
  endtask

  task automatic test_digit_zero();
    for (int i = 0; i < 5; i++) begin
      dash();
      if (i < 4) hold(1'b0, 4);
    end
    hold(1'b0, 12);
    expect_strobe(1'b0, 6'd0);
    hold(1'b0, 16);
    expect_strobe(1'b0, 6'd36);
    hold(1'b0, 2);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL digit_zero_pending: got %0d, want 0", exp_q.size());
    end
  endtask

  task automatic test_letter_r();
    dot();
    hold(1'b0, 4);
    dash();
    hold(1'b0, 11);
    dot();
    hold(1'b0, 12);
    expect_strobe(1'b0, 6'd27);
    hold(1'b0, 16);
    expect_strobe(1'b0, 6'd36);
    hold(1'b0, 2);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL letter_r_pending: got %0d, want 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      dot();
      if (i < 5) hold(1'b0, 4);
    end
    hold(1'b0, 12);
    expect_strobe(1'b1, 6'd0);
    hold(1'b0, 16);
    expect_strobe(1'b0, 6'd36);
    hold(1'b0, 2);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL overflow_pending: got %0d, want 0", exp_q.size());
    end
  endtask

  task automatic test_invalid();
    dash();
    hold(1'b0, 12);
    expect_strobe(1'b0, 6'd29);
    dot();
    hold(1'b0, 4);
    dot();
    hold(1'b0, 4);
    dash();
    hold(1'b0, 4);
    dash();
    hold(1'b0, 12);
    expect_strobe(1'b1, 6'd0);
    hold(1'b0, 2);
    n_vec++;
    if (morse !== 6'd29) begin
      n_err++;
      $display("FAIL morse_hold_after_error: got %0d, want 29", morse);
    end
    hold(1'b0, 14);
    expect_strobe(1'b0, 6'd36);
    hold(1'b0, 2);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL invalid_pending: got %0d, want 0", exp_q.size());
    end
  endtask

  task automatic test_boundaries();
    hold(1'b1, 2 * UNIT - 1);
    hold(1'b0, 4);
    hold(1'b1, 2 * UNIT);
    hold(1'b0, 12);
    expect_strobe(1'b0, 6'd10);
    hold(1'b0, 15);
    hold(1'b1, 30);
    hold(1'b0, 12);
    expect_strobe(1'b0, 6'd29);
    hold(1'b0, 16);
    expect_strobe(1'b0, 6'd36);
    hold(1'b0, 2);
    n_vec++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL boundaries_end: got pending=%0d busy=%b, want 0/0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid_letter();
    dot();
    hold(1'b0, 4);
    dot();
    @(negedge clock);
    reset = 1'b1;
    key   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_morse = 6'd0;
    for (int i = 0; i < 40; i++) begin
      n_vec++;
      if (busy !== 1'b0 || morse !== 6'd0) begin
        n_err++;
        $display("FAIL reset_mid_letter[%0d]: got busy=%b morse=%0d, want 0/0", i, busy, morse);
      end
      hold(1'b0, 1);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_pending: got %0d, want 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    key   = 1'b0;
    fork
      forever begin
        @(negedge clock);
        if (morseReady === 1'b1 && symbolError === 1'b1) begin
          n_vec++;
          n_err++;
          $display("FAIL strobes_overlap: cyc=%0d ready=1 err=1, want at most one", cyc);
        end
        if (morseReady === 1'b1 || symbolError === 1'b1) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe: cyc=%0d ready=%b err=%b morse=%0d, want no strobe",
                     cyc, morseReady, symbolError, morse);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (cyc != e.cyc || symbolError !== e.err || morseReady !== !e.err || morse !== e.sym) begin
              n_err++;
              $display("FAIL strobe: got cyc=%0d ready=%b err=%b morse=%0d, want cyc=%0d ready=%b err=%b morse=%0d",
                       cyc, morseReady, symbolError, morse, e.cyc, !e.err, e.err, e.sym);
            end
          end
        end
      end
    join_none

    test_reset();
    test_letter_e();
    test_digit_zero();
    test_letter_r();
    test_overflow();
    test_invalid();
    test_boundaries();
    test_reset_mid_letter();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/morse_key_sequencer.md
MORSE_KEY_SEQUENCER -- requirements
Module: morse_key_sequencer

Interface
REQ-001 Parameter: UNIT_CYCLES, default 5000000, clock cycles per Morse time unit (100 ms at 50 MHz); legal range 1..2^28-1.
REQ-002 Port: clock  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: key  input  1  debounced key level, 1 = key down (mark); sampled once per clock.
REQ-005 Port: morse  output  6  symbol index to downstream Morse-to-ASCII converter: 0-9 digits, 10-35 A-Z, 36 space.
REQ-006 Port: morseReady  output  1  one-cycle strobe qualifying morse.
REQ-007 Port: symbolError  output  1  one-cycle strobe; the completed letter pattern was invalid.
REQ-008 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 FSM states SHALL be IDLE, MARK, SPACE and WORDGAP; all outputs registered.
REQ-010 IDLE: key=1 SHALL go to MARK with markCount=1; key=0 stays IDLE with no output.
REQ-011 MARK: each key=1 sample SHALL increment markCount, saturating at 2*UNIT_CYCLES.
REQ-012 MARK: first key=0 sample SHALL classify the element (dot if markCount < 2*UNIT_CYCLES, else dash), append it to the pattern, set gapCount=1, and go to SPACE.
REQ-013 Pattern storage SHALL hold up to 5 elements plus a 3-bit length; appending a 6th element SHALL set a sticky overflow flag and leave the stored elements unchanged.
REQ-014 SPACE: key=1 SHALL go to MARK with markCount=1 (intra-letter gap) and clear gapCount.
REQ-015 SPACE: each key=0 sample SHALL increment gapCount; the sample making gapCount == 3*UNIT_CYCLES SHALL end the letter and go to WORDGAP.
REQ-016 Letter end, valid pattern (ITU-R M.1677-1, A-Z or 0-9) with no overflow: the next cycle SHALL assert morseReady=1 with morse = index (digit d -> d, letter -> 10 + alphabet position).
REQ-017 Letter end with overflow or an unlisted pattern: the next cycle SHALL assert symbolError=1 and keep morseReady=0.
REQ-018 Letter end SHALL clear the pattern, length and overflow flag in the same cycle it is evaluated.
REQ-019 WORDGAP: key=1 SHALL go to MARK with markCount=1 and emit no space.
REQ-020 WORDGAP: gapCount continues incrementing on key=0; the sample making gapCount == 7*UNIT_CYCLES SHALL cause morseReady=1, morse=36 on the next cycle, then the FSM goes to IDLE.
REQ-021 The word-gap space SHALL be emitted after an error letter as well as after a valid letter, and at most once per gap.
REQ-022 morseReady and symbolError SHALL each be high for exactly one cycle per event and never high together.
REQ-023 morse SHALL hold its last emitted value between strobes.
REQ-024 Latency: strobe in cycle N+1 for a threshold sample in cycle N.
REQ-025 Counters SHALL be 32-bit unsigned; no wrap is possible within the legal UNIT_CYCLES range.

Reset
REQ-026 Reset=1 at a clock edge SHALL force state IDLE, morse=0, morseReady=0, symbolError=0, busy=0, and clear pattern, length, overflow, markCount and gapCount.
REQ-027 Reset SHALL override key in the same cycle.
REQ-028 Reset mid-letter SHALL discard the partial pattern with no strobe; no space SHALL be emitted from IDLE.

Verification (UNIT_CYCLES=4: dot <8 high samples, dash >=8, letter gap 12 lows, word gap 28 lows)
REQ-029 key high 4, low 28 -> morseReady pulse with morse=14 ('E') one cycle after the 12th low; second pulse with morse=36 one cycle after the 28th low; busy=0 afterwards.
REQ-030 Five dashes (high 8, low 4 between), then low 12 -> single morseReady with morse=0; the 4-cycle intra-letter gaps produce no strobe.
REQ-031 dot, dash, then low 11, then dot, then low 12 -> one morseReady with morse=27 ('R', .-.), with no strobe at the 11-low gap.
REQ-032 Six dots, then low 12 -> symbolError pulse with morseReady=0; after 16 more lows -> morseReady with morse=36.
REQ-033 Pattern ..-- then low 12 -> symbolError pulse, morse unchanged from its prior value.
REQ-034 Two dots, reset for 1 cycle, then low 40 -> no morseReady or symbolError, busy=0 from the cycle after reset.
